// File: rtl/y86_memory_stage.sv
// Y86-64 memory stage: takes one execute result at a time, performs at most one
// data-memory access over a req/rsp interface, and presents a registered result.
module y86_memory_stage #(
  parameter logic [63:0] ADDR_LIMIT = 64'h0000_0000_0001_0000,
  parameter logic [3:0]  RNONE      = 4'hF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_valid,
  output logic        e_ready,
  input  logic [3:0]  e_icode,
  input  logic        e_Cnd,
  input  logic [63:0] e_valE,
  input  logic [63:0] e_valA,
  input  logic [63:0] e_valP,
  input  logic [3:0]  e_dstE,
  input  logic [3:0]  e_dstM,
  input  logic [2:0]  e_stat,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_rsp_valid,
  input  logic [63:0] mem_rdata,
  input  logic        mem_err,
  output logic        w_valid,
  input  logic        w_ready,
  output logic [3:0]  w_icode,
  output logic [63:0] w_valE,
  output logic [63:0] w_valM,
  output logic [3:0]  w_dstE,
  output logic [3:0]  w_dstM,
  output logic [2:0]  w_stat
);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_ADR = 3'd3;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  icode_q;
  logic [63:0] valE_q;
  logic [63:0] valM_q;
  logic [3:0]  dstE_q;
  logic [3:0]  dstM_q;
  logic [2:0]  stat_q;
  logic        we_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;

  logic        isRead, isWrite, memAccess, statOk, addrFault, startReq;
  logic [63:0] accAddr, accData;

  // Access decode straight from the execute inputs; only used on the capture cycle.
  always_comb begin
    isRead  = 1'b0;
    isWrite = 1'b0;
    accAddr = e_valE;
    accData = e_valA;
    case (e_icode)
      4'h5: isRead = 1'b1;
      4'h9, 4'hB: begin
        isRead  = 1'b1;
        accAddr = e_valA;
      end
      4'h4, 4'hA: isWrite = 1'b1;
      4'h8: begin
        isWrite = 1'b1;
        accData = e_valP;
      end
      default: ;
    endcase
  end

  // 65-bit sum so that an address near 2^64 wrapping past zero still faults.
  assign addrFault = ({1'b0, accAddr} + 65'd8) > {1'b0, ADDR_LIMIT};
  assign memAccess = isRead | isWrite;
  assign statOk    = (e_stat == STAT_AOK);
  assign startReq  = statOk & memAccess & ~addrFault;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (e_valid) state_d = startReq ? REQ : DONE;
      REQ:  if (mem_req_ready) state_d = WAIT;
      WAIT: if (mem_rsp_valid) state_d = DONE;
      DONE: if (w_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    e_ready       = (state_q == IDLE);
    mem_req_valid = (state_q == REQ);
    w_valid       = (state_q == DONE);
  end

  // Responses are only observed in WAIT, so one arriving during REQ or after a reset is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      icode_q <= 4'h0;
      valE_q  <= 64'h0;
      valM_q  <= 64'h0;
      dstE_q  <= RNONE;
      dstM_q  <= RNONE;
      stat_q  <= 3'h0;
      we_q    <= 1'b0;
      addr_q  <= 64'h0;
      wdata_q <= 64'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (e_valid) begin
            icode_q <= e_icode;
            valE_q  <= e_valE;
            valM_q  <= 64'h0;
            dstE_q  <= (e_icode == 4'h2 && !e_Cnd) ? RNONE : e_dstE;
            dstM_q  <= e_dstM;
            stat_q  <= (statOk && memAccess && addrFault) ? STAT_ADR : e_stat;
            if (startReq) begin
              addr_q  <= accAddr;
              wdata_q <= accData;
              we_q    <= isWrite;
            end
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            if (mem_err) begin
              stat_q <= STAT_ADR;
              valM_q <= 64'h0;
            end else if (!we_q) begin
              valM_q <= mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign w_icode   = icode_q;
  assign w_valE    = valE_q;
  assign w_valM    = valM_q;
  assign w_dstE    = dstE_q;
  assign w_dstM    = dstM_q;
  assign w_stat    = stat_q;

endmodule

// File: tb/tb_y86_memory_stage.sv
// Directed bench for y86_memory_stage: hand-computed expectations checked with
// immediate assertions after each step.
module tb_y86_memory_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        e_valid;
  logic        e_ready;
  logic [3:0]  e_icode;
  logic        e_Cnd;
  logic [63:0] e_valE, e_valA, e_valP;
  logic [3:0]  e_dstE, e_dstM;
  logic [2:0]  e_stat;
  logic        mem_req_valid, mem_req_ready, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic        mem_rsp_valid, mem_err;
  logic [63:0] mem_rdata;
  logic        w_valid, w_ready;
  logic [3:0]  w_icode, w_dstE, w_dstM;
  logic [63:0] w_valE, w_valM;
  logic [2:0]  w_stat;

  int total = 0;
  int bad   = 0;

  y86_memory_stage dut (
    .clk(clk), .reset(reset),
    .e_valid(e_valid), .e_ready(e_ready), .e_icode(e_icode), .e_Cnd(e_Cnd),
    .e_valE(e_valE), .e_valA(e_valA), .e_valP(e_valP),
    .e_dstE(e_dstE), .e_dstM(e_dstM), .e_stat(e_stat),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .w_valid(w_valid), .w_ready(w_ready), .w_icode(w_icode),
    .w_valE(w_valE), .w_valM(w_valM), .w_dstE(w_dstE), .w_dstM(w_dstM), .w_stat(w_stat)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] icode, input logic cnd, input logic [63:0] valE,
                               input logic [63:0] valA, input logic [63:0] valP,
                               input logic [3:0] dstE, input logic [3:0] dstM, input logic [2:0] stat);
    e_icode = icode; e_Cnd = cnd; e_valE = valE; e_valA = valA; e_valP = valP;
    e_dstE = dstE; e_dstM = dstM; e_stat = stat; e_valid = 1'b1;
    step();
    e_valid = 1'b0;
  endtask

  task automatic releaseResult(input string tag);
    w_ready = 1'b1;
    step();
    w_ready = 1'b0;
    checkOutput({tag, "_idle_ready"}, {63'h0, e_ready}, 64'h1);
    checkOutput({tag, "_idle_wvalid"}, {63'h0, w_valid}, 64'h0);
  endtask

  initial begin
    reset = 1'b1; e_valid = 1'b0; e_icode = 4'h0; e_Cnd = 1'b0;
    e_valE = 64'h0; e_valA = 64'h0; e_valP = 64'h0; e_dstE = 4'hF; e_dstM = 4'hF;
    e_stat = 3'd1; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = 64'h0;
    mem_err = 1'b0; w_ready = 1'b0;
    step(); step();
    reset = 1'b0;

    // reset state
    checkOutput("rst_e_ready", {63'h0, e_ready}, 64'h1);
    checkOutput("rst_req_valid", {63'h0, mem_req_valid}, 64'h0);
    checkOutput("rst_w_valid", {63'h0, w_valid}, 64'h0);
    checkOutput("rst_w_dstE", {60'h0, w_dstE}, 64'hF);
    checkOutput("rst_w_dstM", {60'h0, w_dstM}, 64'hF);
    checkOutput("rst_w_valE", w_valE, 64'h0);
    checkOutput("rst_mem_addr", mem_addr, 64'h0);
    checkOutput("rst_mem_we", {63'h0, mem_we}, 64'h0);

    // opq: straight to DONE
    applyStimulus(4'h6, 1'b1, 64'h15, 64'h0, 64'h0, 4'h3, 4'hF, 3'd1);
    checkOutput("opq_w_valid", {63'h0, w_valid}, 64'h1);
    checkOutput("opq_req_valid", {63'h0, mem_req_valid}, 64'h0);
    checkOutput("opq_e_ready", {63'h0, e_ready}, 64'h0);
    checkOutput("opq_w_icode", {60'h0, w_icode}, 64'h6);
    checkOutput("opq_w_valE", w_valE, 64'h15);
    checkOutput("opq_w_dstE", {60'h0, w_dstE}, 64'h3);
    checkOutput("opq_w_valM", w_valM, 64'h0);
    checkOutput("opq_w_stat", {61'h0, w_stat}, 64'h1);
    releaseResult("opq");

    // mrmovq with request stalled 2 cycles and response 3 cycles after handshake
    applyStimulus(4'h5, 1'b1, 64'h100, 64'h0, 64'h0, 4'hF, 4'h4, 3'd1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("mr_req_valid", {63'h0, mem_req_valid}, 64'h1);
      checkOutput("mr_addr", mem_addr, 64'h100);
      checkOutput("mr_we", {63'h0, mem_we}, 64'h0);
      if (i < 2) step();
    end
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    checkOutput("mr_req_drop", {63'h0, mem_req_valid}, 64'h0);
    step(); step();
    checkOutput("mr_wait_wvalid", {63'h0, w_valid}, 64'h0);
    mem_rsp_valid = 1'b1; mem_rdata = 64'hDEAD_BEEF;
    step();
    mem_rsp_valid = 1'b0; mem_rdata = 64'h0;
    checkOutput("mr_w_valid", {63'h0, w_valid}, 64'h1);
    checkOutput("mr_w_valM", w_valM, 64'hDEAD_BEEF);
    checkOutput("mr_w_stat", {61'h0, w_stat}, 64'h1);
    checkOutput("mr_w_dstM", {60'h0, w_dstM}, 64'h4);
    releaseResult("mr");

    // call: write of valP; an error response in the handshake cycle must be ignored
    applyStimulus(4'h8, 1'b1, 64'hFF8, 64'h999, 64'h40, 4'h4, 4'hF, 3'd1);
    checkOutput("call_we", {63'h0, mem_we}, 64'h1);
    checkOutput("call_addr", mem_addr, 64'hFF8);
    checkOutput("call_wdata", mem_wdata, 64'h40);
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_err = 1'b1;
    step();
    mem_req_ready = 1'b0; mem_err = 1'b0;
    checkOutput("call_in_wait", {63'h0, w_valid}, 64'h0);
    step();
    mem_rsp_valid = 1'b0;
    checkOutput("call_w_valid", {63'h0, w_valid}, 64'h1);
    checkOutput("call_w_stat", {61'h0, w_stat}, 64'h1);
    checkOutput("call_w_valM", w_valM, 64'h0);
    releaseResult("call");

    // cmov not taken, then taken
    applyStimulus(4'h2, 1'b0, 64'h7, 64'h7, 64'h0, 4'h5, 4'hF, 3'd1);
    checkOutput("cmov0_dstE", {60'h0, w_dstE}, 64'hF);
    releaseResult("cmov0");
    applyStimulus(4'h2, 1'b1, 64'h7, 64'h7, 64'h0, 4'h5, 4'hF, 3'd1);
    checkOutput("cmov1_dstE", {60'h0, w_dstE}, 64'h5);
    releaseResult("cmov1");

    // address fault: 0xFFFC + 8 > 0x10000
    applyStimulus(4'h4, 1'b1, 64'hFFFC, 64'h1, 64'h0, 4'hF, 4'hF, 3'd1);
    checkOutput("flt_req_valid", {63'h0, mem_req_valid}, 64'h0);
    checkOutput("flt_w_valid", {63'h0, w_valid}, 64'h1);
    checkOutput("flt_w_stat", {61'h0, w_stat}, 64'h3);
    releaseResult("flt");

    // wrap-around address faults too
    applyStimulus(4'h5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h0, 4'hF, 4'h1, 3'd1);
    checkOutput("wrap_req_valid", {63'h0, mem_req_valid}, 64'h0);
    checkOutput("wrap_w_stat", {61'h0, w_stat}, 64'h3);
    releaseResult("wrap");

    // exactly at the limit: 0xFFF8 + 8 == 0x10000 is legal
    applyStimulus(4'hA, 1'b1, 64'hFFF8, 64'h55, 64'h0, 4'h4, 4'hF, 3'd1);
    checkOutput("edge_req_valid", {63'h0, mem_req_valid}, 64'h1);
    checkOutput("edge_wdata", mem_wdata, 64'h55);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1;
    step();
    mem_rsp_valid = 1'b0;
    checkOutput("edge_w_stat", {61'h0, w_stat}, 64'h1);
    releaseResult("edge");

    // popq with memory error
    applyStimulus(4'hB, 1'b1, 64'h208, 64'h200, 64'h0, 4'h4, 4'h6, 3'd1);
    checkOutput("pop_addr", mem_addr, 64'h200);
    checkOutput("pop_we", {63'h0, mem_we}, 64'h0);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_err = 1'b1; mem_rdata = 64'h1234;
    step();
    mem_rsp_valid = 1'b0; mem_err = 1'b0; mem_rdata = 64'h0;
    checkOutput("pop_w_stat", {61'h0, w_stat}, 64'h3);
    checkOutput("pop_w_valM", w_valM, 64'h0);
    releaseResult("pop");

    // incoming HLT on a memory icode passes through without access
    applyStimulus(4'h5, 1'b1, 64'h100, 64'h0, 64'h0, 4'hF, 4'h2, 3'd2);
    checkOutput("hlt_req_valid", {63'h0, mem_req_valid}, 64'h0);
    checkOutput("hlt_w_valid", {63'h0, w_valid}, 64'h1);
    checkOutput("hlt_w_stat", {61'h0, w_stat}, 64'h2);
    releaseResult("hlt");

    // writeback backpressure: outputs hold while new execute data is offered
    applyStimulus(4'h6, 1'b1, 64'h77, 64'h0, 64'h0, 4'h2, 4'hF, 3'd1);
    e_valid = 1'b1; e_icode = 4'h3; e_valE = 64'hAAAA; e_dstE = 4'h9;
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("bp_w_valid", {63'h0, w_valid}, 64'h1);
      checkOutput("bp_e_ready", {63'h0, e_ready}, 64'h0);
      checkOutput("bp_w_valE", w_valE, 64'h77);
      checkOutput("bp_w_dstE", {60'h0, w_dstE}, 64'h2);
    end
    e_valid = 1'b0;
    releaseResult("bp");

    // reset during WAIT abandons the access; late response ignored
    applyStimulus(4'h5, 1'b1, 64'h300, 64'h0, 64'h0, 4'hF, 4'h7, 3'd1);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("mrst_e_ready", {63'h0, e_ready}, 64'h1);
    checkOutput("mrst_w_valid", {63'h0, w_valid}, 64'h0);
    checkOutput("mrst_req_valid", {63'h0, mem_req_valid}, 64'h0);
    mem_rsp_valid = 1'b1; mem_rdata = 64'hBAD;
    step();
    mem_rsp_valid = 1'b0;
    step();
    checkOutput("late_e_ready", {63'h0, e_ready}, 64'h1);
    checkOutput("late_w_valid", {63'h0, w_valid}, 64'h0);
    checkOutput("late_w_valM", w_valM, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/y86_memory_stage.md
Name: y86_memory_stage

Overview:
Sequential Y86-64 memory stage. It consumes execute-stage results (valE, Cnd) through a valid/ready handshake and resolves conditional moves. It issues at most one data-memory read or write per instruction over a request/response interface, then presents one registered result to writeback. Only one instruction is in flight at a time.

Parameters:
ADDR_LIMIT, 64'h0000_0000_0001_0000, first invalid byte address; an access with addr + 8 > ADDR_LIMIT is an address fault
RNONE, 4'hF, "no register" destination code

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous active-high reset
e_valid  input  1  execute result valid
e_ready  output  1  stage can accept execute result
e_icode  input  4  instruction code
e_Cnd  input  1  condition result from execute
e_valE  input  64  ALU result
e_valA  input  64  operand A / pop-ret stack pointer
e_valP  input  64  next PC (call return address)
e_dstE  input  4  E destination register
e_dstM  input  4  M destination register
e_stat  input  3  incoming status (1 AOK, 2 HLT, 3 ADR, 4 INS)
mem_req_valid  output  1  memory request valid
mem_req_ready  input  1  memory accepts request
mem_we  output  1  1 write, 0 read
mem_addr  output  64  byte address
mem_wdata  output  64  write data
mem_rsp_valid  input  1  response valid (read data or write ack)
mem_rdata  input  64  read data
mem_err  input  1  response error, qualified by mem_rsp_valid
w_valid  output  1  result valid to writeback
w_ready  input  1  writeback accepts result
w_icode  output  4  registered icode
w_valE  output  64  registered valE
w_valM  output  64  loaded value, 0 if no read
w_dstE  output  4  E destination after cmov resolution
w_dstM  output  4  M destination
w_stat  output  3  final status

Behaviour:
- Reset: state=IDLE; e_ready=1; mem_req_valid=0; w_valid=0; all w_* data outputs 0; w_dstE=w_dstM=RNONE; mem_addr, mem_wdata, mem_we=0.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: e_ready=1. On e_valid, capture all e_* inputs into internal registers.
  - Captured stat != AOK, or icode has no memory access: go to DONE next cycle.
  - Memory icode with a valid address: go to REQ.
  - Memory icode with an address fault: no request is issued; stat becomes ADR (3); go to DONE.
- Access decode:
  - Read: 5 mrmovq (addr=valE), B popq (addr=valA), 9 ret (addr=valA).
  - Write: 4 rmmovq (addr=valE, data=valA), A pushq (addr=valE, data=valA), 8 call (addr=valE, data=valP).
  - All other icodes: no access.
- cmov: icode 2 with Cnd=0 forces dstE to RNONE. All other icodes pass dstE unchanged.
- REQ: mem_req_valid=1 with addr, wdata and we stable until mem_req_ready is sampled 1; then WAIT. mem_req_valid drops the cycle after the handshake.
- WAIT: on mem_rsp_valid:
  - mem_err=1 sets stat=ADR and valM=0.
  - Otherwise a read latches valM=mem_rdata; a write leaves valM=0.
  - Then DONE.
  - A response arriving in the same cycle as the request handshake is ignored. The memory guarantees at least 1 cycle of latency.
- DONE: w_valid=1; w_* stable until w_ready=1; then IDLE.
  - e_ready=0 in REQ, WAIT and DONE, so no skid buffering.
  - Minimum occupancy: 2 cycles for non-memory instructions, 4 cycles for memory instructions.
- w_* outputs are registered; no combinational path from e_* to w_* or from mem_* to w_*.
- Incoming stat HLT/ADR/INS passes through unchanged with no memory access, even for memory icodes.
- Reset mid-transaction (REQ or WAIT) abandons the access. Any later response is ignored because IDLE does not observe mem_rsp_valid.
- Address fault check uses 65-bit arithmetic so that addr + 8 wrap-around is detected as a fault.

Test Plan:
- Reset then IDLE; opq icode 6, valE=0x15, dstE=3 -> w_valid in cycle 2, w_valE=0x15, w_dstE=3, w_valM=0, w_stat=1, mem_req_valid never asserted.
- mrmovq valE=0x100, memory returns 0xDEADBEEF after 3 cycles with mem_req_ready delayed 2 cycles -> mem_addr=0x100, mem_we=0 held stable through the stall; w_valM=0xDEADBEEF, stat=1.
- call valE=0xFF8, valP=0x40 -> mem_we=1, mem_addr=0xFF8, mem_wdata=0x40; after ack, w_stat=1, w_valM=0.
- cmov icode 2, Cnd=0, dstE=5 -> w_dstE=F; repeat with Cnd=1 -> w_dstE=5.
- rmmovq valE=0xFFFC (limit 0x10000) -> no request, w_stat=3. popq with mem_err=1 -> w_stat=3, w_valM=0. e_stat=2 with mrmovq -> no request, w_stat=2.
- w_ready held 0 for 5 cycles -> w_* stable, e_ready=0. Assert reset during WAIT -> next cycle IDLE, w_valid=0; late mem_rsp_valid is ignored.
